// File: rtl/hit_arbiter.sv
// rtl/hit_arbiter.sv - round-robin arbiter merging per-lane hit FIFOs into one fragment stream
module hit_arbiter #(
    parameter int SIGFIG  = 24,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 3,
    parameter int DEPTH   = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [SAMPLES-1:0]                       hit_valid_in,
    input  logic [SAMPLES*SIGFIG-1:0]                hit_x_in,
    input  logic [SAMPLES*SIGFIG-1:0]                hit_y_in,
    input  logic [SAMPLES*SIGFIG-1:0]                hit_z_in,
    input  logic [SAMPLES*COLORS*SIGFIG-1:0]         hit_color_in,
    output logic [SAMPLES-1:0]                       lane_full_out,
    output logic                                     frag_valid_out,
    input  logic                                     frag_ready_in,
    output logic [SIGFIG-1:0]                        frag_x_out,
    output logic [SIGFIG-1:0]                        frag_y_out,
    output logic [SIGFIG-1:0]                        frag_z_out,
    output logic [COLORS*SIGFIG-1:0]                 frag_color_out,
    output logic [(SAMPLES > 1 ? $clog2(SAMPLES) : 1)-1:0] frag_lane_out,
    output logic [15:0]                              frag_count_out,
    output logic                                     idle_out
);

    localparam int CLRW = COLORS * SIGFIG;
    localparam int EW   = 3 * SIGFIG + CLRW;
    localparam int LW   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW   = $clog2(DEPTH + 1);

    logic [EW-1:0]      mem [SAMPLES][DEPTH];
    logic [EW-1:0]      lane_entry [SAMPLES];
    logic [PW-1:0]      wr_ptr [SAMPLES];
    logic [PW-1:0]      rd_ptr [SAMPLES];
    logic [NW-1:0]      count [SAMPLES];
    logic [SAMPLES-1:0] push;
    logic [SAMPLES-1:0] pop;
    logic [SAMPLES-1:0] nonempty;
    logic [LW-1:0]      rr_ptr;
    logic [LW-1:0]      grant;
    logic               grant_found;
    logic               load;
    logic [EW-1:0]      head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Entry layout, LSB first: x, y, z, color.
    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            lane_entry[i] = {hit_color_in[i*CLRW +: CLRW],
                             hit_z_in[i*SIGFIG +: SIGFIG],
                             hit_y_in[i*SIGFIG +: SIGFIG],
                             hit_x_in[i*SIGFIG +: SIGFIG]};
        end
    end

    // Fullness comes from the registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            lane_full_out[i] = (count[i] == NW'(DEPTH));
            nonempty[i]      = (count[i] != '0);
            push[i]          = hit_valid_in[i] && !lane_full_out[i];
        end
    end

    always_comb begin
        logic [LW:0] idx;
        idx         = '0;
        grant       = rr_ptr;
        grant_found = 1'b0;
        for (int off = 0; off < SAMPLES; off++) begin
            idx = {1'b0, rr_ptr} + (LW+1)'(off);
            if (idx >= (LW+1)'(SAMPLES)) begin
                idx = idx - (LW+1)'(SAMPLES);
            end
            if (!grant_found && nonempty[idx[LW-1:0]]) begin
                grant_found = 1'b1;
                grant       = idx[LW-1:0];
            end
        end
    end

    assign load = !frag_valid_out || frag_ready_in;
    assign head = mem[grant][rd_ptr[grant]];

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            pop[i] = load && grant_found && (grant == LW'(i));
        end
    end

    // Storage itself needs no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SAMPLES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= lane_entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SAMPLES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SAMPLES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + NW'(1);
                    2'b01:   count[i] <= count[i] - NW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frag_valid_out <= 1'b0;
            frag_x_out     <= '0;
            frag_y_out     <= '0;
            frag_z_out     <= '0;
            frag_color_out <= '0;
            frag_lane_out  <= '0;
        end else if (load) begin
            if (grant_found) begin
                frag_valid_out <= 1'b1;
                frag_x_out     <= head[0 +: SIGFIG];
                frag_y_out     <= head[SIGFIG +: SIGFIG];
                frag_z_out     <= head[2*SIGFIG +: SIGFIG];
                frag_color_out <= head[3*SIGFIG +: CLRW];
                frag_lane_out  <= grant;
            end else begin
                frag_valid_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (load && grant_found) begin
            rr_ptr <= (grant == LW'(SAMPLES - 1)) ? '0 : grant + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frag_count_out <= '0;
        end else if (frag_valid_out && frag_ready_in && (frag_count_out != 16'hFFFF)) begin
            frag_count_out <= frag_count_out + 16'd1;
        end
    end

    assign idle_out = (nonempty == '0) && !frag_valid_out;

endmodule

// File: tb/tb_hit_arbiter.sv
// tb/tb_hit_arbiter.sv - scoreboard bench for hit_arbiter with directed vectors
module tb_hit_arbiter;

    localparam int SF = 24;
    localparam int NC = 3;
    localparam int NS = 3;
    localparam int DP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     hit_valid_in;
    logic [NS*SF-1:0]  hit_x_in, hit_y_in, hit_z_in;
    logic [NS*NC*SF-1:0] hit_color_in;
    logic [NS-1:0]     lane_full_out;
    logic              frag_valid_out;
    logic              frag_ready_in;
    logic [SF-1:0]     frag_x_out, frag_y_out, frag_z_out;
    logic [NC*SF-1:0]  frag_color_out;
    logic [1:0]        frag_lane_out;
    logic [15:0]       frag_count_out;
    logic              idle_out;

    hit_arbiter #(.SIGFIG(SF), .COLORS(NC), .SAMPLES(NS), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .hit_valid_in(hit_valid_in), .hit_x_in(hit_x_in), .hit_y_in(hit_y_in),
        .hit_z_in(hit_z_in), .hit_color_in(hit_color_in),
        .lane_full_out(lane_full_out),
        .frag_valid_out(frag_valid_out), .frag_ready_in(frag_ready_in),
        .frag_x_out(frag_x_out), .frag_y_out(frag_y_out), .frag_z_out(frag_z_out),
        .frag_color_out(frag_color_out), .frag_lane_out(frag_lane_out),
        .frag_count_out(frag_count_out), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
        logic [71:0] c;
    } frag_t;

    frag_t exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic frag_t mk(input int lane, input int seq);
        frag_t f;
        f.lane = lane;
        f.x = {4'(lane), 4'h1, 16'(seq)};
        f.y = {4'(lane), 4'h2, 16'(seq)};
        f.z = {4'(lane), 4'h3, 16'(seq)};
        f.c = {4'(lane), 4'hC, 16'(seq), 4'(lane), 4'hB, 16'(seq), 4'(lane), 4'hA, 16'(seq)};
        return f;
    endfunction

    task automatic set_hit(input frag_t f);
        hit_valid_in[f.lane]          = 1'b1;
        hit_x_in[f.lane*SF +: SF]     = f.x;
        hit_y_in[f.lane*SF +: SF]     = f.y;
        hit_z_in[f.lane*SF +: SF]     = f.z;
        hit_color_in[f.lane*72 +: 72] = f.c;
    endtask

    task automatic clr_hits();
        hit_valid_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_hits();
        frag_ready_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int maxc);
        for (int k = 0; k < maxc && exp_q.size() != 0; k++) tick();
        tick();
        chk({name, "_drain"}, 96'(exp_q.size()), 96'd0);
        chk({name, "_idle"}, 96'(idle_out), 96'd1);
    endtask

    // Monitor: every accepted fragment must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        frag_t e;
        if (!rst && frag_valid_out && frag_ready_in) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected actual lane=%0d x=%h required=none", frag_lane_out, frag_x_out);
            end else begin
                e = exp_q.pop_front();
                if (e.lane != int'(frag_lane_out) || e.x !== frag_x_out || e.y !== frag_y_out ||
                    e.z !== frag_z_out || e.c !== frag_color_out) begin
                    fails++;
                    $display("FAIL sb_frag actual lane=%0d x=%h y=%h z=%h c=%h required lane=%0d x=%h y=%h z=%h c=%h",
                             frag_lane_out, frag_x_out, frag_y_out, frag_z_out, frag_color_out,
                             e.lane, e.x, e.y, e.z, e.c);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frag_t f;
        bit    p0, p2;
        int    s0, s2;

        rst = 1'b1;
        hit_valid_in = '0;
        hit_x_in = '0; hit_y_in = '0; hit_z_in = '0; hit_color_in = '0;
        frag_ready_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", 96'(frag_valid_out), 96'd0);
        chk("rst_idle",  96'(idle_out), 96'd1);
        chk("rst_full",  96'(lane_full_out), 96'd0);
        chk("rst_lane",  96'(frag_lane_out), 96'd0);
        chk("rst_x",     96'(frag_x_out), 96'd0);
        chk("rst_y",     96'(frag_y_out), 96'd0);
        chk("rst_z",     96'(frag_z_out), 96'd0);
        chk("rst_color", 96'(frag_color_out), 96'd0);
        chk("rst_count", 96'(frag_count_out), 96'd0);

        // Single hit on lane 1, two-edge latency.
        frag_ready_in = 1'b1;
        f = mk(1, 0);
        f.x = 24'h000400;
        f.y = 24'h000800;
        set_hit(f);
        exp_q.push_back(f);
        tick();
        clr_hits();
        chk("single_lat_edge0", 96'(frag_valid_out), 96'd0);
        tick();
        chk("single_valid", 96'(frag_valid_out), 96'd1);
        chk("single_lane",  96'(frag_lane_out), 96'd1);
        chk("single_x",     96'(frag_x_out), 96'h000400);
        chk("single_y",     96'(frag_y_out), 96'h000800);
        tick();
        chk("single_count", 96'(frag_count_out), 96'd1);
        chk("single_idle",  96'(idle_out), 96'd1);

        // All lanes at once, twice: order 0,1,2 both rounds shows rr_ptr returns to 0.
        do_reset();
        frag_ready_in = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < 3; l++) begin
                set_hit(mk(l, 1 + r));
                exp_q.push_back(mk(l, 1 + r));
            end
            tick();
            clr_hits();
            for (int l = 0; l < 3; l++) begin
                tick();
                chk("rr3_valid", 96'(frag_valid_out), 96'd1);
                chk("rr3_lane",  96'(frag_lane_out), 96'(l));
            end
        end
        drain("rr3", 10);

        // Backpressure: lane 0 hits every cycle while ready is low.
        do_reset();
        frag_ready_in = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 10 + k));
        for (int k = 0; k < 5; k++) begin
            set_hit(mk(0, 10 + k));
            tick();
            if (k == 1) chk("bp_not_full", 96'(lane_full_out[0]), 96'd0);
            if (k >= 1) begin
                chk("bp_valid_hold", 96'(frag_valid_out), 96'd1);
                chk("bp_x_hold",     96'(frag_x_out), 96'(mk(0, 10).x));
                chk("bp_z_hold",     96'(frag_z_out), 96'(mk(0, 10).z));
            end
            if (k >= 2) chk("bp_full", 96'(lane_full_out[0]), 96'd1);
        end
        clr_hits();
        frag_ready_in = 1'b1;
        drain("bp", 10);
        chk("bp_count", 96'(frag_count_out), 96'd3);

        // Fairness: lanes 0 and 2 continuously, upstream halting on full.
        do_reset();
        frag_ready_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk(0, 20 + k));
            exp_q.push_back(mk(2, 20 + k));
        end
        s0 = 0;
        s2 = 0;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) begin
            clr_hits();
            p0 = (s0 < 6) && !lane_full_out[0];
            p2 = (s2 < 6) && !lane_full_out[2];
            if (p0) set_hit(mk(0, 20 + s0));
            if (p2) set_hit(mk(2, 20 + s2));
            tick();
            if (p0) s0++;
            if (p2) s2++;
        end
        clr_hits();
        chk("fair_s0", 96'(s0), 96'd6);
        chk("fair_s2", 96'(s2), 96'd6);
        drain("fair", 10);

        // Reset mid-stream with buffered fragments and a hit during the reset edge.
        do_reset();
        frag_ready_in = 1'b1;
        set_hit(mk(1, 30));
        exp_q.push_back(mk(1, 30));
        tick();
        clr_hits();
        tick();
        tick();
        chk("mid_pre_count", 96'(frag_count_out), 96'd1);
        frag_ready_in = 1'b0;
        for (int l = 0; l < 3; l++) set_hit(mk(l, 40));
        tick();
        clr_hits();
        set_hit(mk(0, 41));
        set_hit(mk(1, 41));
        tick();
        clr_hits();
        chk("mid_pre_valid", 96'(frag_valid_out), 96'd1);
        chk("mid_pre_idle",  96'(idle_out), 96'd0);
        rst = 1'b1;
        set_hit(mk(0, 50));
        frag_ready_in = 1'b1;
        tick();
        rst = 1'b0;
        clr_hits();
        exp_q.delete();
        chk("mid_valid", 96'(frag_valid_out), 96'd0);
        chk("mid_idle",  96'(idle_out), 96'd1);
        chk("mid_count", 96'(frag_count_out), 96'd0);
        chk("mid_full",  96'(lane_full_out), 96'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_no_stale", 96'(frag_valid_out), 96'd0);
        end

        // Saturation: 65537 deliveries from lane 0 at full rate.
        do_reset();
        frag_ready_in = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            clr_hits();
            if (!lane_full_out[0]) begin
                f = mk(0, i);
                set_hit(f);
                exp_q.push_back(f);
            end
            tick();
            if (i == 99) chk("thru_count", 96'(frag_count_out), 96'd98);
        end
        clr_hits();
        drain("sat", 10);
        chk("sat_count", 96'(frag_count_out), 96'hFFFF);
        tick();
        tick();
        chk("sat_hold", 96'(frag_count_out), 96'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hit_arbiter.md
HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per coordinate/color word.
REQ-002 SHALL have parameter COLORS, default 3, meaning color channels per fragment.
REQ-003 SHALL have parameter SAMPLES, default 3, meaning sample-test lanes arbitrated.
REQ-004 SHALL have parameter DEPTH, default 2, meaning per-lane buffer entries.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port hit_valid_in  input  SAMPLES  per-lane hit present.
REQ-008 SHALL have port hit_x_in  input  SAMPLES*SIGFIG  per-lane screen x, lane i at bits [i*SIGFIG +: SIGFIG].
REQ-009 SHALL have port hit_y_in  input  SAMPLES*SIGFIG  per-lane screen y, same packing.
REQ-010 SHALL have port hit_z_in  input  SAMPLES*SIGFIG  per-lane depth, same packing.
REQ-011 SHALL have port hit_color_in  input  SAMPLES*COLORS*SIGFIG  per-lane color, lane i at bits [i*COLORS*SIGFIG +: COLORS*SIGFIG].
REQ-012 SHALL have port lane_full_out  output  SAMPLES  lane i buffer holds DEPTH entries.
REQ-013 SHALL have port frag_valid_out  output  1  output fragment present.
REQ-014 SHALL have port frag_ready_in  input  1  downstream accepts fragment.
REQ-015 SHALL have port frag_x_out, frag_y_out, frag_z_out  output  SIGFIG each  granted fragment fields.
REQ-016 SHALL have port frag_color_out  output  COLORS*SIGFIG  granted fragment color.
REQ-017 SHALL have port frag_lane_out  output  clog2(SAMPLES)  source lane of current fragment.
REQ-018 SHALL have port frag_count_out  output  16  fragments delivered since reset, saturating.
REQ-019 SHALL have port idle_out  output  1  all buffers empty and frag_valid_out low.

Function
REQ-020 SHALL push lane i when hit_valid_in[i]=1 and lane_full_out[i]=0; hit_valid_in[i] with lane_full_out[i]=1 is dropped (upstream halts on lane_full_out).
REQ-021 SHALL compute lane_full_out[i] from the registered lane count only; no push to a full lane even on a same-cycle pop.
REQ-022 SHALL hold each lane as an in-order FIFO of DEPTH entries, wrap-around read/write pointers, count 0..DEPTH.
REQ-023 SHALL define output register load condition LOAD = (frag_valid_out=0 or frag_ready_in=1).
REQ-024 SHALL, when LOAD and at least one lane non-empty, grant one lane by round-robin starting at priority pointer rr_ptr, pop its head into the output register, set frag_valid_out=1.
REQ-025 SHALL, when LOAD and all lanes empty, clear frag_valid_out.
REQ-026 SHALL update rr_ptr to (granted lane + 1) mod SAMPLES on each grant; unchanged otherwise.
REQ-027 SHALL hold all frag_*_out stable while frag_valid_out=1 and frag_ready_in=0.
REQ-028 SHALL have latency 2: hit pushed at edge k into empty arbiter appears with frag_valid_out=1 after edge k+1.
REQ-029 SHALL sustain 1 fragment/cycle when frag_ready_in=1 and any lane non-empty.
REQ-030 SHALL allow push and pop on the same lane in one cycle (count unchanged).
REQ-031 SHALL increment frag_count_out on each cycle with frag_valid_out=1 and frag_ready_in=1, saturating at 16'hFFFF.
REQ-032 SHALL guarantee no lane starves: a non-empty lane is granted within SAMPLES grants.

Reset
REQ-033 SHALL, with rst=1 at a rising edge, set all lane counts/pointers to 0, rr_ptr=0, frag_valid_out=0, frag_count_out=0, and ignore hit_valid_in that cycle.
REQ-034 SHALL output lane_full_out=0, idle_out=1, frag_lane_out=0, and frag_x/y/z/color_out=0 after reset.
REQ-035 SHALL discard all buffered and in-flight fragments on reset asserted mid-operation.

Verification
REQ-036 SHALL cover single hit: lane 1 x=0x000400,y=0x000800 at edge 0, ready=1 -> valid after edge 1, lane=1, fields match, count=1.
REQ-037 SHALL cover all 3 lanes hit same cycle, ready=1 -> fragments in lane order 0,1,2 on consecutive cycles, rr_ptr=0 after.
REQ-038 SHALL cover ready=0 held 5 cycles with lane 0 hitting every cycle -> lane_full_out[0]=1 after 2 pushes plus 1 in output register, outputs stable, extra hits dropped, 3 fragments delivered in order.
REQ-039 SHALL cover fairness: lanes 0 and 2 hit continuously, ready=1 -> grants alternate 0,2,0,2.
REQ-040 SHALL cover reset mid-stream with 4 buffered fragments -> after reset edge valid=0, idle_out=1, count=0, no stale fragment emerges.
REQ-041 SHALL cover count saturation: preload via 65536 deliveries -> frag_count_out holds 16'hFFFF.
